// File: rtl/bin2bcd_display.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_display
// Description : Sequential double-dabble binary-to-packed-BCD converter that
//               feeds the 8-digit 7-segment scan driver. Optional periodic
//               self-triggering is enabled with macro AUTO_CONV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_display #(
    parameter int BIN_W       = 27,
    parameter int REFRESH_CYC = 5000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [31:0]      data_out
);

    localparam int          CNT_W       = 5;
    localparam logic [26:0] C_OVF_LIMIT = 27'd99_999_999;
    localparam logic [31:0] C_OVF_WORD  = 32'hEEEE_EEEE;

    generate
        if (BIN_W < 1 || BIN_W > 27) begin : g_bad_bin_w
            $error("bin2bcd_display: BIN_W must be in 1..27");
        end
        if (REFRESH_CYC < BIN_W + 2) begin : g_bad_refresh
            $error("bin2bcd_display: REFRESH_CYC must be at least BIN_W+2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [BIN_W-1:0] r_bin;
    logic [31:0]      r_bcd;
    logic [31:0]      w_bcd_adj;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf_pending;
    logic             w_start_eff;
    logic             w_accept;
    logic             w_finish;
    logic             w_last_shift;
    logic             w_ovf_in;

    // Every digit >= 5 gets +3 before the shift so it carries correctly.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_adj
            assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                          (r_bcd[4*gi +: 4] + 4'd3) :
                                          r_bcd[4*gi +: 4];
        end
    endgenerate

    assign w_last_shift = (r_cnt == CNT_W'(BIN_W - 1));
    // Values below 2^26 can never exceed the limit, so narrow builds fold to 0.
    assign w_ovf_in     = (27'(bin_in) > C_OVF_LIMIT);

`ifdef AUTO_CONV_EN
    localparam int RCNT_W = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;

    logic [RCNT_W-1:0] r_refresh_cnt;
    logic              r_auto_req;
    logic              w_wrap;

    assign w_wrap      = (r_refresh_cnt == RCNT_W'(REFRESH_CYC - 1));
    assign w_start_eff = start | r_auto_req;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_refresh_cnt <= '0;
            r_auto_req    <= 1'b0;
        end else begin
            r_refresh_cnt <= w_wrap ? '0 : r_refresh_cnt + RCNT_W'(1);
            // A wrap on the accepting edge raises a fresh request.
            if (w_accept) begin
                r_auto_req <= 1'b0;
            end
            if (w_wrap) begin
                r_auto_req <= 1'b1;
            end
        end
    end
`else
    assign w_start_eff = start;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_eff) begin
                    w_accept     = 1'b1;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last_shift) begin
                    w_state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                w_finish     = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bin         <= '0;
            r_bcd         <= '0;
            r_cnt         <= '0;
            r_ovf_pending <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            ovf           <= 1'b0;
            data_out      <= '0;
        end else begin
            done <= w_finish;
            if (w_accept) begin
                r_bin         <= bin_in;
                r_bcd         <= '0;
                r_cnt         <= '0;
                r_ovf_pending <= w_ovf_in;
                busy          <= 1'b1;
            end
            if (r_state == S_SHIFT) begin
                r_bcd <= {w_bcd_adj[30:0], r_bin[BIN_W-1]};
                r_bin <= r_bin << 1;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_finish) begin
                data_out <= r_ovf_pending ? C_OVF_WORD : r_bcd;
                ovf      <= r_ovf_pending;
                busy     <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin2bcd_display
// Description : Self-checking bench for bin2bcd_display (BIN_W=27); covers the
//               AUTO_CONV_EN refresh path when that macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_display;

    localparam int BIN_W   = 27;
    localparam int LAT     = BIN_W + 1;
    localparam int TIMEOUT = 300;

    logic             clk;
    logic             rst_n;
    logic [BIN_W-1:0] bin_in;
    logic             start;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [31:0]      data_out;

    int n_checks = 0;
    int n_fail   = 0;

    bin2bcd_display #(
        .BIN_W      (BIN_W),
        .REFRESH_CYC(100)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bin_in  (bin_in),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf),
        .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [BIN_W-1:0] bin;
        logic [31:0]      exp_data;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic launch(input logic [BIN_W-1:0] v);
        bin_in = v;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Counts falling edges until done is seen; busy_cnt counts busy-high samples.
    task automatic wait_done(output int n, output int busy_cnt);
        n        = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && n < TIMEOUT) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic expect_no_done(input string name, input int cycles);
        int seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    initial begin
        int n;
        int bc;

        vecs[0] = '{27'd12345678,  32'h1234_5678, 1'b0};
        vecs[1] = '{27'd0,         32'h0000_0000, 1'b0};
        vecs[2] = '{27'd99999999,  32'h9999_9999, 1'b0};
        vecs[3] = '{27'd100000000, 32'hEEEE_EEEE, 1'b1};
        vecs[4] = '{27'd42,        32'h0000_0042, 1'b0};
        vecs[5] = '{27'd134217727, 32'hEEEE_EEEE, 1'b1};
        vecs[6] = '{27'd1,         32'h0000_0001, 1'b0};
        vecs[7] = '{27'd10,        32'h0000_0010, 1'b0};
        vecs[8] = '{27'd65535,     32'h0006_5535, 1'b0};
        vecs[9] = '{27'd99999998,  32'h9999_9998, 1'b0};

        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ovf",  32'(ovf),  32'd0);
        check("reset_data", data_out,  32'h0);

`ifdef AUTO_CONV_EN
        bin_in = 27'd7;
        wait_done(n, bc);
        check("auto_first_done_seen", 32'(done), 32'd1);
        check("auto_data0", data_out, 32'h0000_0007);
        for (int r = 1; r <= 3; r++) begin
            @(negedge clk);
            wait_done(n, bc);
            check("auto_period", 32'(n + 1), 32'd100);
            check("auto_data", data_out, 32'h0000_0007);
        end
`else
        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].bin);
            wait_done(n, bc);
            check("latency",    32'(n),  32'(LAT));
            check("busy_cycles", 32'(bc), 32'(LAT));
            check("data",       data_out, vecs[i].exp_data);
            check("ovf",        32'(ovf), 32'(vecs[i].exp_ovf));
            @(negedge clk);
            check("done_one_cycle", 32'(done), 32'd0);
        end

        // Back-to-back: second start issued in the done cycle of the first.
        launch(27'd0);
        wait_done(n, bc);
        check("b2b_data0", data_out, 32'h0);
        launch(27'd99999999);
        wait_done(n, bc);
        check("b2b_spacing", 32'(n + 1), 32'(LAT + 1));
        check("b2b_data1", data_out, 32'h9999_9999);
        @(negedge clk);

        // Starts during busy are ignored and bin_in changes have no effect.
        launch(27'd777);
        n = 0;
        while (done !== 1'b1 && n < TIMEOUT) begin
            start  = (n == 5 || n == 10 || n == 20);
            bin_in = (n >= 5) ? 27'd1234 : 27'd777;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("ignore_latency", 32'(n), 32'(LAT));
        check("ignore_data", data_out, 32'h0000_0777);
        expect_no_done("ignore_single_done", 40);
        check("ignore_data_held", data_out, 32'h0000_0777);

        // Reset mid-conversion aborts without a done pulse.
        launch(27'd555);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_data", data_out,  32'h0);
        expect_no_done("abort_no_done", 40);
        launch(27'd555);
        wait_done(n, bc);
        check("restart_latency", 32'(n), 32'(LAT));
        check("restart_data", data_out, 32'h0000_0555);
        check("restart_ovf",  32'(ovf),  32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bin2bcd_display.md
Name: bin2bcd_display

Overview:
- Sequential double-dabble converter that sits directly upstream of the 8-digit 7-segment scan driver and produces its 32-bit data word.
- Converts an unsigned binary value, such as a light-pen hit count or coordinate, into 8 packed BCD digits so the panel shows decimal instead of hex.
- Uses one adjust+shift step per clock with a start/busy/done handshake.
- The output word is held stable between conversions, so the scan driver never sees partial results.

Parameters:
- BIN_W, 27, width of binary input; legal range 1..27. An elaboration-time check fails outside this range.
- REFRESH_CYC, 5000000, auto-conversion period in clk cycles. Used only with AUTO_CONV_EN; minimum legal value BIN_W+2.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- bin_in  input  BIN_W  unsigned binary value, sampled only on an accepted start
- start  input  1  conversion request, level-sampled each edge
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when data_out has just been updated
- ovf  output  1  high when the last accepted value exceeded 99_999_999
- data_out  output  32  packed BCD: digit0 (units) in [3:0] through digit7 in [31:28]; feeds the scan driver data input

Behaviour:
- Reset: when rst_n=0 at a clk edge:
  - state=IDLE
  - busy=0, done=0, ovf=0, data_out=32'h0000_0000
  - shift/BCD scratch registers and bit counter cleared
- Reset mid-conversion aborts the conversion with no done pulse.
- FSM states: IDLE, SHIFT, FINISH.
- IDLE:
  - start=1 at edge E0 captures bin_in into the binary shift register.
  - At E0: clears the 32-bit BCD scratch, sets counter=0, busy=1, latches ovf_pending=(bin_in > 99_999_999) and goes to SHIFT.
  - ovf_pending is always 0 when BIN_W<27.
- SHIFT:
  - Each edge, every 4-bit BCD scratch digit >=5 gets +3 (combinational, all 8 digits in parallel).
  - Then {bcd, bin} shift left by 1, MSB of bin entering bcd[0].
  - Counter increments.
  - On the edge performing shift number BIN_W (edge E_BIN_W), go to FINISH.
- FINISH, at edge E_BIN_W+1:
  - data_out <= ovf_pending ? 32'hEEEE_EEEE : bcd scratch.
  - ovf <= ovf_pending; done <= 1; busy <= 0; state -> IDLE.
- done is high exactly one cycle, in the cycle after E_BIN_W+1.
- Latency from start edge to done high is BIN_W+1 edges; busy is high for BIN_W+1 cycles.
- start while busy=1 is ignored and not queued.
- start=1 in the cycle where done=1 is accepted, since state is already IDLE. This allows back-to-back conversions every BIN_W+2 cycles.
- start held high continuously produces repeated conversions, re-sampling bin_in at each acceptance.
- data_out and ovf change only at the FINISH edge or on reset. bin_in changes during a conversion have no effect.
- Adjust arithmetic is 4-bit per digit; no carry between digits beyond what the shift provides. Digit 7 is never adjusted out of range for legal inputs.

Optional Feature:
- Macro AUTO_CONV_EN.
- Defined:
  - A free-running counter counts 0..REFRESH_CYC-1 and wraps; it resets to 0.
  - On wrap it sets an internal auto_req flag.
  - In IDLE, an effective start = start | auto_req is accepted, and acceptance clears auto_req.
  - A wrap occurring while busy leaves auto_req pending until IDLE.
  - The display therefore refreshes from bin_in every REFRESH_CYC cycles with no external start.
- Undefined: no counter or auto_req logic is present; only the external start launches conversions.

Test Plan:
- Reset, then start with bin_in=12345678 (BIN_W=27) -> busy high 28 cycles, done pulse at edge 28 after start, data_out=32'h12345678, ovf=0.
- bin_in=0, then bin_in=99999999 back-to-back with start asserted in the done cycle -> data_out=32'h00000000, then 32'h99999999 exactly 29 cycles later.
- bin_in=100000000 -> data_out=32'hEEEEEEEE, ovf=1; the next conversion of 42 -> data_out=32'h00000042, ovf=0.
- start pulsed at cycles 5, 10 and 20 after an accepted start, with bin_in changed -> all ignored, a single done, and data_out reflects only the first captured value.
- rst_n=0 for one edge at shift 10 of a conversion of 555 -> no done pulse, busy=0, data_out=0; a new start of 555 -> 32'h00000555.
- With AUTO_CONV_EN, REFRESH_CYC=100, bin_in=7, no start -> done pulses every 100 cycles, data_out=32'h00000007.
